// File: rtl/intra_pred_nxn.sv
// BLK x BLK luma intra predictor (vertical / horizontal / DC / mid-grey) with
// neighbour-availability fallback; streams one predicted row per handshake.
module intra_pred_nxn #(
  parameter int BLK   = 4,
  parameter int PIX_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [BLK*PIX_W-1:0]   top,
  input  logic [BLK*PIX_W-1:0]   left,
  input  logic                   top_avail,
  input  logic                   left_avail,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLK*PIX_W-1:0]   out_row,
  output logic [$clog2(BLK)-1:0] out_row_idx,
  output logic                   done,
  output logic                   mode_err
);
  localparam int IDX_W = $clog2(BLK);
  localparam int LOG_B = $clog2(BLK);
  localparam int SW    = PIX_W + $clog2(2*BLK);
  localparam logic [PIX_W-1:0] MID = {1'b1, {(PIX_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;
  typedef enum logic [1:0] {EFF_V, EFF_H, EFF_DC, EFF_MID} eff_t;

  state_t               state_q, state_d;
  eff_t                 eff_q, eff_d;
  logic [BLK*PIX_W-1:0] top_q, top_d, left_q, left_d;
  logic [1:0]           mode_q, mode_d;
  logic                 tav_q, tav_d, lav_q, lav_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d, valid_q, valid_d;
  logic                 done_q, done_d, mode_err_q, mode_err_d;
  logic [BLK*PIX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [SW-1:0]        sum_t, sum_l;
  logic [PIX_W-1:0]     dc_val, left_pix;
  logic [IDX_W-1:0]     row_sel;
  logic [BLK*PIX_W-1:0] row_pred;

  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int i = 0; i < BLK; i++) begin
      sum_t = sum_t + SW'(top_q[i*PIX_W +: PIX_W]);
      sum_l = sum_l + SW'(left_q[i*PIX_W +: PIX_W]);
    end
  end

  // sum_q already carries the rounding term; only the divide is left here.
  always_comb begin
    if (tav_q && lav_q)      dc_val = PIX_W'(sum_q >> (LOG_B + 1));
    else if (tav_q || lav_q) dc_val = PIX_W'(sum_q >> LOG_B);
    else                     dc_val = MID;
  end

  // Row being prepared: row 0 on entry to EMIT, otherwise the successor.
  always_comb begin
    row_sel  = valid_q ? idx_q + 1'b1 : '0;
    left_pix = left_q[row_sel*PIX_W +: PIX_W];
  end

  generate
    for (genvar gi = 0; gi < BLK; gi++) begin : g_col
      assign row_pred[gi*PIX_W +: PIX_W] =
        (eff_q == EFF_V)  ? top_q[gi*PIX_W +: PIX_W] :
        (eff_q == EFF_H)  ? left_pix :
        (eff_q == EFF_DC) ? dc_val : MID;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    eff_d      = eff_q;
    top_d      = top_q;
    left_d     = left_q;
    mode_d     = mode_q;
    tav_d      = tav_q;
    lav_d      = lav_q;
    sum_d      = sum_q;
    err_d      = err_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    row_d      = row_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    mode_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          top_d   = top;
          left_d  = left;
          mode_d  = mode;
          tav_d   = top_avail;
          lav_d   = left_avail;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (tav_q && lav_q) sum_d = sum_t + sum_l + SW'(BLK);
        else if (tav_q)     sum_d = sum_t + SW'(BLK/2);
        else if (lav_q)     sum_d = sum_l + SW'(BLK/2);
        else                sum_d = '0;
        err_d = 1'b0;
        case (mode_q)
          2'd0: begin eff_d = tav_q ? EFF_V : EFF_MID; err_d = !tav_q; end
          2'd1: begin eff_d = lav_q ? EFF_H : EFF_MID; err_d = !lav_q; end
          2'd2: eff_d = EFF_DC;
          default: eff_d = EFF_MID;
        endcase
        state_d = EMIT;
      end
      EMIT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          idx_d   = '0;
          row_d   = row_pred;
        end else if (out_ready) begin
          if (idx_q == IDX_W'(BLK-1)) begin
            valid_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            mode_err_d = err_q;
            state_d    = IDLE;
          end else begin
            idx_d = row_sel;
            row_d = row_pred;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      eff_q      <= EFF_MID;
      top_q      <= '0;
      left_q     <= '0;
      mode_q     <= '0;
      tav_q      <= 1'b0;
      lav_q      <= 1'b0;
      sum_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      row_q      <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      eff_q      <= eff_d;
      top_q      <= top_d;
      left_q     <= left_d;
      mode_q     <= mode_d;
      tav_q      <= tav_d;
      lav_q      <= lav_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign out_row     = row_q;
  assign out_row_idx = idx_q;
  assign done        = done_q;
  assign mode_err    = mode_err_q;
endmodule

// File: tb/tb_intra_pred_nxn.sv
// Bench for intra_pred_nxn at BLK=4/8/16: per-cycle behavioural model check
// plus directed literal cases and randomized blocks.
module tb_intra_pred_nxn;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, out_ready, top_avail, left_avail;
  logic [1:0]   mode;
  logic [127:0] top_bus, left_bus;
  int           sel;
  int           total = 0;
  int           bad = 0;

  logic s4, s8, s16;
  assign s4  = start && (sel == 0);
  assign s8  = start && (sel == 1);
  assign s16 = start && (sel == 2);

  logic b4, v4, d4, e4, b8, v8, d8, e8, b16, v16, d16, e16;
  logic [31:0]  r4;
  logic [63:0]  r8;
  logic [127:0] r16;
  logic [1:0]   i4;
  logic [2:0]   i8;
  logic [3:0]   i16;

  intra_pred_nxn #(.BLK(4), .PIX_W(8)) u4 (
    .clk(clk), .reset(reset), .start(s4), .mode(mode),
    .top(top_bus[31:0]), .left(left_bus[31:0]),
    .top_avail(top_avail), .left_avail(left_avail),
    .busy(b4), .out_valid(v4), .out_ready(out_ready),
    .out_row(r4), .out_row_idx(i4), .done(d4), .mode_err(e4));
  intra_pred_nxn #(.BLK(8), .PIX_W(8)) u8 (
    .clk(clk), .reset(reset), .start(s8), .mode(mode),
    .top(top_bus[63:0]), .left(left_bus[63:0]),
    .top_avail(top_avail), .left_avail(left_avail),
    .busy(b8), .out_valid(v8), .out_ready(out_ready),
    .out_row(r8), .out_row_idx(i8), .done(d8), .mode_err(e8));
  intra_pred_nxn #(.BLK(16), .PIX_W(8)) u16 (
    .clk(clk), .reset(reset), .start(s16), .mode(mode),
    .top(top_bus), .left(left_bus),
    .top_avail(top_avail), .left_avail(left_avail),
    .busy(b16), .out_valid(v16), .out_ready(out_ready),
    .out_row(r16), .out_row_idx(i16), .done(d16), .mode_err(e16));

  logic         o_busy, o_valid, o_done, o_err;
  logic [127:0] o_row;
  logic [3:0]   o_idx;
  always_comb begin
    o_busy = b4; o_valid = v4; o_done = d4; o_err = e4;
    o_row  = 128'(r4); o_idx = 4'(i4);
    if (sel == 1) begin
      o_busy = b8; o_valid = v8; o_done = d8; o_err = e8;
      o_row  = 128'(r8); o_idx = 4'(i8);
    end else if (sel == 2) begin
      o_busy = b16; o_valid = v16; o_done = d16; o_err = e16;
      o_row  = r16; o_idx = i16;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int tv[16], lv[16];          // values currently driven
  int mt[16], ml[16];          // values latched by the model at start
  int m_blk, m_mode, m_ph, m_ptr;
  bit m_ta, m_la;
  logic         exp_busy = 0, exp_valid = 0, exp_done = 0, exp_err = 0;
  logic [127:0] exp_row = '0;
  logic [3:0]   exp_idx = '0;
  logic [127:0] cap[16];
  int           cap_n = 0;

  function automatic int blk_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 8 : 16;
  endfunction

  function automatic int model_pix(input int r, input int c);
    int st = 0;
    int sl = 0;
    for (int i = 0; i < m_blk; i++) begin
      st += mt[i];
      sl += ml[i];
    end
    case (m_mode)
      0: return m_ta ? mt[c] : 128;
      1: return m_la ? ml[r] : 128;
      2: begin
        if (m_ta && m_la) return (st + sl + m_blk) / (2 * m_blk);
        if (m_ta) return (st + m_blk / 2) / m_blk;
        if (m_la) return (sl + m_blk / 2) / m_blk;
        return 128;
      end
      default: return 128;
    endcase
  endfunction

  function automatic logic [127:0] build_row(input int r);
    logic [127:0] v = '0;
    int p;
    for (int c = 0; c < m_blk; c++) begin
      p = model_pix(r, c);
      v[c*8 +: 8] = p[7:0];
    end
    return v;
  endfunction

  // Phases: 0 idle, 1 computing, 2 first row pending, 3 streaming rows.
  always @(negedge clk) begin
    if (reset) begin
      exp_busy = 0; exp_valid = 0; exp_done = 0; exp_err = 0;
      exp_row = '0; exp_idx = '0; m_ph = 0;
    end
    chk("busy", o_busy, exp_busy);
    chk("out_valid", o_valid, exp_valid);
    chk("done", o_done, exp_done);
    chk("mode_err", o_err, exp_err);
    if (exp_valid || reset) begin
      chk("out_row", o_row, exp_row);
      chk("out_row_idx", o_idx, exp_idx);
    end
    if (!reset) begin
      if (o_valid && out_ready) begin
        cap[o_idx] = o_row;
        cap_n++;
      end
      exp_done = 0;
      exp_err  = 0;
      case (m_ph)
        0: if (start) begin
          m_blk = blk_of(sel); m_mode = int'(mode);
          m_ta = top_avail; m_la = left_avail;
          for (int i = 0; i < 16; i++) begin mt[i] = tv[i]; ml[i] = lv[i]; end
          exp_busy = 1; m_ph = 1;
        end
        1: m_ph = 2;
        2: begin
          m_ptr = 0; exp_valid = 1; exp_idx = 0; exp_row = build_row(0); m_ph = 3;
        end
        default: if (out_ready) begin
          if (m_ptr == m_blk - 1) begin
            exp_valid = 0; exp_busy = 0; exp_done = 1;
            exp_err = (m_mode == 0 && !m_ta) || (m_mode == 1 && !m_la);
            m_ph = 0;
          end else begin
            m_ptr++; exp_idx = 4'(m_ptr); exp_row = build_row(m_ptr);
          end
        end
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < 16; i++) begin
      top_bus[i*8 +: 8]  = tv[i][7:0];
      left_bus[i*8 +: 8] = lv[i][7:0];
    end
  endtask

  task automatic rand_vals();
    for (int i = 0; i < 16; i++) begin
      tv[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
      lv[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
    end
  endtask

  // style: 0 out_ready held high, 1 random out_ready, 2 three-cycle stall on row 1.
  // Styles 1 and 2 also pulse start during EMIT, which must be ignored.
  task automatic run_block(input int s, input int md, input bit ta, input bit la,
                           input int style, output int cyc, output bit err_seen,
                           output int ncap);
    int  bp = 0;
    int  c0;
    bit  got = 0;
    if (s != sel) tick();
    sel = s; mode = 2'(md); top_avail = ta; left_avail = la; pack();
    out_ready = 1; start = 1;
    c0 = cap_n;
    tick();
    start = 0;
    rand_vals(); mode = 2'($urandom); top_avail = 1'($urandom); left_avail = 1'($urandom); pack();
    cyc = 0; err_seen = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      tick();
      cyc++;
      if (o_done) begin
        got = 1; err_seen = o_err; start = 0; out_ready = 1;
      end else begin
        case (style)
          1: out_ready = 1'($urandom_range(0, 1));
          2: if (o_valid && o_idx == 4'd1 && bp < 3) begin out_ready = 0; bp++; end
             else out_ready = 1;
          default: out_ready = 1;
        endcase
        start = (style != 0) && o_valid && ($urandom_range(0, 3) == 0);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    ncap = cap_n - c0;
  endtask

  int cyc, ncap;
  bit err_seen;
  logic [31:0] w;

  initial begin
    reset = 1; start = 0; out_ready = 1; sel = 0; mode = 0;
    top_avail = 0; left_avail = 0; top_bus = '0; left_bus = '0;
    for (int i = 0; i < 16; i++) begin tv[i] = 0; lv[i] = 0; end
    tick(); tick(); tick();
    reset = 0;
    tick();

    // Vertical, BLK=4
    tv[0] = 10; tv[1] = 20; tv[2] = 30; tv[3] = 40;
    for (int i = 0; i < 4; i++) lv[i] = 7;
    run_block(0, 0, 1, 1, 0, cyc, err_seen, ncap);
    chk("vert_latency", 32'(cyc), 32'd6);
    chk("vert_err", err_seen, 0);
    chk("vert_rows", 32'(ncap), 32'd4);
    for (int r = 0; r < 4; r++) chk("vert_row", cap[r][31:0], 32'h281e140a);

    // Horizontal, BLK=4 (started in the done cycle of the previous block)
    for (int i = 0; i < 4; i++) lv[i] = i + 1;
    run_block(0, 1, 1, 1, 0, cyc, err_seen, ncap);
    for (int r = 0; r < 4; r++) begin
      w = 32'h01010101 * 32'(r + 1);
      chk("horiz_row", cap[r][31:0], w);
    end

    // DC variants, BLK=4
    for (int i = 0; i < 4; i++) begin tv[i] = 100; lv[i] = i + 1; end
    run_block(0, 2, 1, 1, 0, cyc, err_seen, ncap);
    chk("dc_both", cap[2][31:0], 32'h33333333);
    tv[0] = 10; tv[1] = 20; tv[2] = 30; tv[3] = 40;
    run_block(0, 2, 1, 0, 0, cyc, err_seen, ncap);
    chk("dc_top_only", cap[3][31:0], 32'h19191919);
    run_block(0, 2, 0, 0, 0, cyc, err_seen, ncap);
    chk("dc_none", cap[0][31:0], 32'h80808080);
    chk("dc_none_err", err_seen, 0);

    // BLK=16 DC saturation and vertical without top
    for (int i = 0; i < 16; i++) begin tv[i] = 255; lv[i] = 255; end
    run_block(2, 2, 1, 1, 0, cyc, err_seen, ncap);
    chk("dc16_rows", 32'(ncap), 32'd16);
    for (int r = 0; r < 16; r++) chk("dc16_row", cap[r], {128{1'b1}});
    run_block(2, 0, 0, 1, 0, cyc, err_seen, ncap);
    chk("v16_noavail_err", err_seen, 1);
    chk("v16_noavail_row", cap[5], {16{8'h80}});

    // BLK=8 backpressure on row 1, stray start pulses during EMIT
    for (int i = 0; i < 8; i++) lv[i] = 3 * i + 11;
    run_block(1, 1, 1, 1, 2, cyc, err_seen, ncap);
    chk("bp_rows", 32'(ncap), 32'd8);
    chk("bp_latency", 32'(cyc), 32'd13);
    chk("bp_row1", cap[1][63:0], {8{8'd14}});

    // Reset while row 2 is presented
    rand_vals();
    run_block(0, 3, 1, 1, 0, cyc, err_seen, ncap);
    sel = 0; mode = 0; top_avail = 1; left_avail = 1; pack(); start = 1;
    tick(); start = 0;
    for (int n = 0; n < 20 && !(o_valid && o_idx == 4'd2); n++) tick();
    chk("reached_idx2", o_idx, 4'd2);
    reset = 1;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_idx", o_idx, 0);
    tick();
    reset = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("rst_no_done", o_done, 0);
    end
    tv[0] = 1; tv[1] = 2; tv[2] = 3; tv[3] = 4;
    run_block(0, 0, 1, 1, 0, cyc, err_seen, ncap);
    chk("after_rst_row", cap[3][31:0], 32'h04030201);

    // Randomized blocks
    for (int k = 0; k < 60; k++) begin
      rand_vals();
      run_block(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                cyc, err_seen, ncap);
      chk("rand_rows", 32'(ncap), 32'(blk_of(sel)));
    end

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
